// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream program loader and a CPU read port; IDLE/LOAD/RUN/ERR FSM.
// Reads have zero-cycle latency; loader backpressure is via wr_ready. Optional checksum gate: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int         DEPTH = 256,
    parameter logic [7:0] NOP   = 8'h00
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       load_start,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    output logic       wr_ready,
    input  logic [7:0] read_address,
    output logic [7:0] instruction,
    output logic       cpu_run,
    output logic [8:0] load_count,
    output logic       overflow_err
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    input  logic [7:0] expected_sum,
    output logic [7:0] checksum,
    output logic       checksum_ok
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

    localparam logic [8:0] DEPTH_CNT = 9'(DEPTH);

    state_t     state_q, state_d;
    logic [8:0] load_count_q, load_count_d;
    logic [7:0] mem [DEPTH];
    logic       hs;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;
`endif

    assign hs         = wr_valid & wr_ready;
    assign load_count = load_count_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= IDLE;
            load_count_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    // Program storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (hs) begin
            mem[load_count_q[7:0]] <= wr_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif
        case (state_q)
            LOAD: begin
                if (load_start) begin
                    load_count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum_d   = '0;
`endif
                end else if (hs) begin
                    load_count_d = load_count_q + 9'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum_d   = checksum_q + wr_data;
`endif
                    if (wr_last) begin
                        state_d = RUN;
                    end
                end else if (load_count_q == DEPTH_CNT) begin
                    state_d = ERR;
                end
            end
            default: begin
                if (load_start) begin
                    state_d      = LOAD;
                    load_count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum_d   = '0;
`endif
                end
            end
        endcase
    end

    always_comb begin
        wr_ready     = (state_q == LOAD) && !load_start && (load_count_q < DEPTH_CNT);
        overflow_err = (state_q == ERR);
        instruction  = NOP;
        if ((state_q == RUN) && ({1'b0, read_address} < load_count_q)) begin
            instruction = mem[read_address];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum    = checksum_q;
        checksum_ok = (state_q == RUN) && (checksum_q == expected_sum);
        cpu_run     = checksum_ok;
`else
        cpu_run     = (state_q == RUN);
`endif
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load/run, restart, overflow, async clear and optional checksum gate.
module tb_imem_loader;

    logic       clock = 1'b0;
    logic       clear;
    logic       load_start;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       wr_ready;
    logic [7:0] read_address;
    logic [7:0] instruction;
    logic       cpu_run;
    logic [8:0] load_count;
    logic       overflow_err;
    logic [7:0] exp_sum;
    logic [7:0] run_sum;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] checksum;
    logic       checksum_ok;
`endif

    int checks   = 0;
    int failures = 0;

    imem_loader dut (
        .clock       (clock),
        .clear       (clear),
        .load_start  (load_start),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .wr_ready    (wr_ready),
        .read_address(read_address),
        .instruction (instruction),
        .cpu_run     (cpu_run),
        .load_count  (load_count),
        .overflow_err(overflow_err)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .expected_sum(exp_sum),
        .checksum    (checksum),
        .checksum_ok (checksum_ok)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        wr_valid   = 1'b0;
        tick();
        load_start = 1'b0;
        run_sum    = 8'h00;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        run_sum  = run_sum + d;
        if (last) exp_sum = run_sum;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] expv);
        read_address = a;
        #1;
        chk(tag, 32'(instruction), 32'(expv));
    endtask

    initial begin
        clear = 1'b1; load_start = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        wr_last = 1'b0; read_address = 8'h00; exp_sum = 8'h00; run_sum = 8'h00;
        #3;
        chk("rst_cpu_run", 32'(cpu_run), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_count", 32'(load_count), 0);
        chk("rst_ovf", 32'(overflow_err), 0);
        chk("rst_instr", 32'(instruction), 0);
        tick(); tick();
        clear = 1'b0;

        // Basic three-byte program.
        start_load();
        #1;
        chk("load_wr_ready", 32'(wr_ready), 1);
        chk("load_cpu_run", 32'(cpu_run), 0);
        send(8'h41, 1'b0);
        chk("cnt_after_1", 32'(load_count), 1);
        send(8'h82, 1'b0);
        send(8'hC3, 1'b1);
        chk("run_cpu_run", 32'(cpu_run), 1);
        chk("run_count", 32'(load_count), 3);
        chk("run_wr_ready", 32'(wr_ready), 0);
        rd("rd0", 8'd0, 8'h41);
        rd("rd1", 8'd1, 8'h82);
        rd("rd2", 8'd2, 8'hC3);
        rd("rd3", 8'd3, 8'h00);

        // Restart mid-load while wr_valid is held.
        start_load();
        send(8'h11, 1'b0);
        chk("restart_pre_cnt", 32'(load_count), 1);
        load_start = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
        #1;
        chk("restart_wr_ready", 32'(wr_ready), 0);
        tick();
        load_start = 1'b0; wr_valid = 1'b0; run_sum = 8'h00;
        chk("restart_cnt", 32'(load_count), 0);
        send(8'h55, 1'b1);
        chk("restart_run", 32'(cpu_run), 1);
        chk("restart_cnt1", 32'(load_count), 1);
        rd("restart_rd0", 8'd0, 8'h55);
        rd("restart_rd1", 8'd1, 8'h00);

        // Overflow: 256 bytes with no wr_last.
        start_load();
        for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
        chk("ovf_cnt256", 32'(load_count), 256);
        chk("ovf_wr_ready", 32'(wr_ready), 0);
        chk("ovf_cpu_run", 32'(cpu_run), 0);
        wr_valid = 1'b1;
        tick();
        chk("ovf_err", 32'(overflow_err), 1);
        chk("ovf_err_ready", 32'(wr_ready), 0);
        tick();
        wr_valid = 1'b0;
        chk("ovf_cnt_hold", 32'(load_count), 256);
        chk("ovf_err_run", 32'(cpu_run), 0);
        start_load();
        chk("ovf_cleared", 32'(overflow_err), 0);
        chk("ovf_cnt_zero", 32'(load_count), 0);

        // Full 256-byte program with wr_last on the final byte.
        for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5A, i == 255);
        chk("full_run", 32'(cpu_run), 1);
        chk("full_ovf", 32'(overflow_err), 0);
        chk("full_cnt", 32'(load_count), 256);
        rd("full_rd0", 8'd0, 8'h5A);
        rd("full_rd80", 8'h80, 8'hDA);
        rd("full_rdff", 8'hFF, 8'hA5);

        // Asynchronous clear between edges.
        #2;
        clear = 1'b1;
        #1;
        chk("aclr_cpu_run", 32'(cpu_run), 0);
        chk("aclr_instr", 32'(instruction), 0);
        chk("aclr_cnt", 32'(load_count), 0);
        chk("aclr_wr_ready", 32'(wr_ready), 0);
        tick();
        clear = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        #1;
        chk("post_clr_load", 32'(wr_ready), 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        start_load();
        send(8'hFF, 1'b0);
        send(8'h02, 1'b1);
        exp_sum = 8'h01;
        #1;
        chk("cks_value", 32'(checksum), 32'h01);
        chk("cks_ok", 32'(checksum_ok), 1);
        chk("cks_run", 32'(cpu_run), 1);
        exp_sum = 8'h00;
        #1;
        chk("cks_bad_ok", 32'(checksum_ok), 0);
        chk("cks_bad_run", 32'(cpu_run), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 8-bit instruction words stored (address width 8).
REQ-002 SHALL have parameter NOP, default 8'h00, meaning the instruction value returned for unloaded addresses and outside RUN.
REQ-003 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port clear  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port load_start  input  1  begins or restarts a program load.
REQ-006 SHALL have port wr_valid  input  1  loader byte valid.
REQ-007 SHALL have port wr_data  input  8  loader instruction byte.
REQ-008 SHALL have port wr_last  input  1  marks the final byte of a program; qualified by wr_valid.
REQ-009 SHALL have port wr_ready  output  1  block accepts wr_data this cycle.
REQ-010 SHALL have port read_address  input  8  instruction address from the CPU program counter.
REQ-011 SHALL have port instruction  output  8  instruction word to the CPU.
REQ-012 SHALL have port cpu_run  output  1  high only in RUN; the program image is valid.
REQ-013 SHALL have port load_count  output  9  number of bytes accepted in the current or last load (0..256).
REQ-014 SHALL have port overflow_err  output  1  load exceeded DEPTH without wr_last.

Function
REQ-015 SHALL implement states IDLE, LOAD, RUN, ERR, encoded in one registered state variable.
REQ-016 IDLE->LOAD, RUN->LOAD and ERR->LOAD SHALL occur on the cycle after load_start=1; entering LOAD SHALL zero load_count and overflow_err.
REQ-017 load_start=1 while in LOAD SHALL restart the load: load_count SHALL go to 0 and no byte SHALL be written that cycle.
REQ-018 wr_ready SHALL be 1 only in LOAD while load_start=0 and load_count<DEPTH; it SHALL be combinational from state and count.
REQ-019 A handshake (wr_valid & wr_ready) SHALL write wr_data to mem[load_count[7:0]] and increment load_count on the same edge.
REQ-020 A handshake with wr_last=1 SHALL move the state to RUN on that edge, with cpu_run=1 from the next cycle.
REQ-021 If load_count reaches DEPTH in LOAD without wr_last, the state SHALL move to ERR on the next edge; overflow_err SHALL be 1 in ERR, and further bytes SHALL be refused.
REQ-022 A 256th-byte handshake with wr_last=1 SHALL go to RUN, not ERR.
REQ-023 In RUN, instruction SHALL equal mem[read_address] combinationally (zero-cycle latency) when read_address<load_count, else NOP.
REQ-024 In IDLE, LOAD and ERR, instruction SHALL be NOP and cpu_run SHALL be 0.
REQ-025 wr_valid without wr_ready SHALL have no effect; wr_data SHALL not be sampled.
REQ-026 Memory contents SHALL be retained across load restarts; only load_count bounds visibility.

Reset
REQ-027 clear=1 SHALL immediately force state=IDLE, load_count=0, overflow_err=0, cpu_run=0, wr_ready=0 and instruction=NOP, with no clock edge required.
REQ-028 clear SHALL abort a load or RUN at any point; memory array contents SHALL be undefined and are not reset.
REQ-029 The first load_start after clear is deasserted SHALL be honoured on the first clock edge.

Configuration
REQ-030 With macro IMEM_LOADER_CHECKSUM_EN defined, the block SHALL add input expected_sum[7:0] and outputs checksum[7:0] and checksum_ok.
REQ-031 checksum SHALL be the modulo-256 sum of bytes accepted since entering LOAD, cleared on LOAD entry and on clear.
REQ-032 checksum_ok SHALL be 1 only in RUN with checksum==expected_sum; a mismatch SHALL hold cpu_run=0 while the state remains RUN.
REQ-033 Without the macro, these ports and this logic SHALL be absent and cpu_run SHALL follow REQ-012 unconditionally.

Verification
REQ-034 Reset, then load_start and bytes 8'h41,8'h82,8'hC3 with wr_last on the third -> cpu_run=1, load_count=3; read_address 0/1/2/3 -> 8'h41/8'h82/8'hC3/NOP.
REQ-035 Hold wr_valid=1 with load_start=1 for a cycle mid-load -> wr_ready=0, no write, load_count=0 next cycle.
REQ-036 Load 256 bytes without wr_last -> wr_ready=0 after byte 256, ERR, overflow_err=1, cpu_run=0; load_start then clears overflow_err.
REQ-037 Assert clear asynchronously between clock edges in RUN -> cpu_run=0 and instruction=NOP before the next edge.
REQ-038 With IMEM_LOADER_CHECKSUM_EN defined, load 8'hFF,8'h02 with expected_sum=8'h01 -> checksum_ok=1 and cpu_run=1; with expected_sum=8'h00 -> checksum_ok=0 and cpu_run=0.
